keypad_scan: RTL and testbench

4x4 matrix keypad scanner running on CLK_1K. It drives columns, debounces rows and encodes the pressed key. It emits exactly one single-cycle flag pulse per press, with a stable key_value, to the calculator input controller. It is the producer side of the key_value/flag interface: digits 0x0-0x9, operators 0xA-0xD, equals 0xE, clear 0xF.

---
 rtl/kp_pkg.sv | 64 ++++++
 rtl/kp_sync2.sv | 22 ++
 rtl/keypad_scan.sv | 111 +++++++++++
 tb/tb_keypad_scan.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/kp_pkg.sv
// Shared definitions for the keypad scanner and its consumers: FSM state
// encoding, key code constants and the row/column to key code map.
package kp_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESS    = 2'd2,
    RELEASE  = 2'd3
  } kp_state_t;

  localparam logic [3:0] KEY_ADD = 4'hA;
  localparam logic [3:0] KEY_SUB = 4'hB;
  localparam logic [3:0] KEY_MUL = 4'hC;
  localparam logic [3:0] KEY_DIV = 4'hD;
  localparam logic [3:0] KEY_EQ  = 4'hE;
  localparam logic [3:0] KEY_CLR = 4'hF;

  // Physical layout: rows top to bottom, columns left to right.
  //   r0: 1 2 3 +    r1: 4 5 6 -    r2: 7 8 9 *    r3: C 0 = /
  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = KEY_ADD;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = KEY_SUB;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = KEY_MUL;
      4'b11_00: code = KEY_CLR;
      4'b11_01: code = 4'h0;
      4'b11_10: code = KEY_EQ;
      default:  code = KEY_DIV;
    endcase
    return code;
  endfunction

  // True when exactly one row line is pulled low.
  function automatic logic one_low(input logic [3:0] rows);
    return ($countones(~rows) == 1);
  endfunction

  // Index of the lowest active-low row line.
  function automatic logic [1:0] row_index(input logic [3:0] rows);
    logic [1:0] idx;
    if (!rows[0])      idx = 2'd0;
    else if (!rows[1]) idx = 2'd1;
    else if (!rows[2]) idx = 2'd2;
    else               idx = 2'd3;
    return idx;
  endfunction

  // One-cold column drive pattern for a column index.
  function automatic logic [3:0] col_drive(input logic [1:0] col);
    return ~(4'b0001 << col);
  endfunction

endpackage

// File: rtl/kp_sync2.sv
// Two-flop synchronizer for the asynchronous, pulled-up keypad row lines.
module kp_sync2 (
  input  logic       CLK_1K,
  input  logic       RST,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] meta;

  // Idle (released) rows read as all ones, so reset to that level.
  always_ff @(posedge CLK_1K or negedge RST) begin
    if (!RST) begin
      meta <= 4'hF;
      q    <= 4'hF;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: walks a low column across the keypad, debounces
// the row response on press and release, and emits one flag pulse per key.
module keypad_scan
  import kp_pkg::*;
#(
  parameter int SCAN_DWELL   = 4,
  parameter int DEBOUNCE_CYC = 20,
  parameter int CNT_W        = 5
) (
  input  logic       CLK_1K,
  input  logic       RST,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_value,
  output logic       flag,
  output logic       key_down
);

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(SCAN_DWELL - 1);
  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYC - 1);

  logic [3:0]       rows;
  logic [3:0]       row_latch;
  logic [1:0]       col_idx;
  logic [1:0]       next_col;
  logic [CNT_W-1:0] cnt;
  kp_state_t        state;

  kp_sync2 u_sync (
    .CLK_1K (CLK_1K),
    .RST    (RST),
    .d      (row_in),
    .q      (rows)
  );

  assign next_col = col_idx + 2'd1;

  // Scan/debounce/press/release sequencer; one counter serves dwell and debounce.
  always_ff @(posedge CLK_1K or negedge RST) begin
    if (!RST) begin
      state     <= SCAN;
      col_idx   <= 2'd0;
      col_out   <= 4'b1110;
      cnt       <= '0;
      row_latch <= 4'hF;
      key_value <= 4'h0;
      flag      <= 1'b0;
      key_down  <= 1'b0;
    end else begin
      flag <= 1'b0;
      case (state)
        SCAN: begin
          if (cnt == DWELL_LAST) begin
            if (rows == 4'hF) begin
              col_idx <= next_col;
              col_out <= col_drive(next_col);
              cnt     <= '0;
            end else begin
              row_latch <= rows;
              cnt       <= CNT_W'(1);
              state     <= DEBOUNCE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DEBOUNCE: begin
          if (rows != row_latch) begin
            col_idx <= next_col;
            col_out <= col_drive(next_col);
            cnt     <= '0;
            state   <= SCAN;
          end else if (cnt == DEB_LAST) begin
            cnt   <= '0;
            state <= one_low(row_latch) ? PRESS : RELEASE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        PRESS: begin
          key_value <= key_map(row_index(row_latch), col_idx);
          flag      <= 1'b1;
          key_down  <= 1'b1;
          cnt       <= '0;
          state     <= RELEASE;
        end

        RELEASE: begin
          if (rows == 4'hF) begin
            if (cnt == DEB_LAST) begin
              key_down <= 1'b0;
              col_idx  <= next_col;
              col_out  <= col_drive(next_col);
              cnt      <= '0;
              state    <= SCAN;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else begin
            cnt <= '0;
          end
        end

        default: state <= SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// Self-checking bench for keypad_scan: a keypad matrix model drives the rows
// from the scanner's columns, and a per-cycle checker compares the flag and
// key_value stream against the queue of keys the stimulus says must register.
module tb_keypad_scan;

  localparam int SCAN_DWELL   = 4;
  localparam int DEBOUNCE_CYC = 20;

  // Expected code for each key position [row][col], read off the keypad legend.
  localparam logic [3:0] KEYCODE [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hF, 4'h0, 4'hE, 4'hD}
  };
  localparam logic [3:0] COL_SEQ [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  logic       CLK_1K = 1'b0;
  logic       RST = 1'b1;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] key_value;
  logic       flag;
  logic       key_down;

  logic [3:0] key_mat [4] = '{default: 4'h0};

  logic [3:0] exp_q [$];
  logic [3:0] model_val = 4'h0;
  logic       prev_flag = 1'b0;

  int checks = 0;
  int passes = 0;

  keypad_scan #(
    .SCAN_DWELL   (SCAN_DWELL),
    .DEBOUNCE_CYC (DEBOUNCE_CYC),
    .CNT_W        (5)
  ) dut (
    .CLK_1K    (CLK_1K),
    .RST       (RST),
    .row_in    (row_in),
    .col_out   (col_out),
    .key_value (key_value),
    .flag      (flag),
    .key_down  (key_down)
  );

  always #5 CLK_1K = ~CLK_1K;

  // Keypad matrix: a row reads low when any pressed key in it sits on a driven column.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      if ((key_mat[r] & ~col_out) != 4'h0) row_in[r] = 1'b0;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  task automatic applyStimulus(input int r, input int c, input logic v);
    key_mat[r][c] = v;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge CLK_1K);
  endtask

  // Wait until the scanner has just started driving column c.
  task automatic alignCol(input int c);
    int n = 0;
    while (col_out[c] == 1'b0 && n < 64) begin @(negedge CLK_1K); n++; end
    while (col_out[c] == 1'b1 && n < 128) begin @(negedge CLK_1K); n++; end
    if (n >= 128) checkOutput("align_timeout", 32'(n), 32'd0);
  endtask

  // Count negedges until flag is seen (or budget runs out).
  task automatic measureFlag(input string name, input int budget, output int k);
    k = 0;
    do begin @(negedge CLK_1K); k++; end while (!flag && k < budget);
    if (!flag) checkOutput({name, "_timeout"}, 32'(k), 32'(budget + 1));
  endtask

  task automatic measureRelease(input string name, input int budget, output int k);
    k = 0;
    do begin @(negedge CLK_1K); k++; end while (key_down && k < budget);
    if (key_down) checkOutput({name, "_timeout"}, 32'(k), 32'(budget + 1));
  endtask

  // Per-cycle checker: flags must match the expected key queue in order,
  // key_value must hold between flags, columns must stay one-cold.
  always @(negedge CLK_1K) begin
    if (!RST) begin
      model_val = 4'h0;
      prev_flag = 1'b0;
      checkOutput("reset_flag", 32'(flag), 32'd0);
      checkOutput("reset_key_value", 32'(key_value), 32'd0);
      checkOutput("reset_key_down", 32'(key_down), 32'd0);
      checkOutput("reset_col_out", 32'(col_out), 32'hE);
    end else begin
      checkOutput("col_one_cold", 32'($countones(~col_out)), 32'd1);
      if (flag) begin
        checkOutput("flag_not_consecutive", 32'(prev_flag), 32'd0);
        checkOutput("flag_key_down", 32'(key_down), 32'd1);
        if (exp_q.size() == 0) begin
          checks++;
          $display("[TB] FAIL unexpected_flag: got flag with key_value=%0h, required no flag", key_value);
        end else begin
          model_val = exp_q.pop_front();
          checkOutput("flag_key_value", 32'(key_value), 32'(model_val));
        end
      end else begin
        checkOutput("key_value_held", 32'(key_value), 32'(model_val));
      end
      prev_flag = flag;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int k;
    int seq_r [5] = '{0, 0, 0, 0, 3};
    int seq_c [5] = '{0, 1, 3, 2, 2};

    // Reset, then watch the idle column rotation.
    #1 RST = 1'b0;
    waitCycles(3);
    #1 RST = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge CLK_1K);
      checkOutput("idle_col_rotation", 32'(col_out), 32'(COL_SEQ[(i / SCAN_DWELL) % 4]));
    end
    checkOutput("idle_key_value", 32'(key_value), 32'h0);

    // Key '5' held clean: flag lands SCAN_DWELL + DEBOUNCE_CYC cycles after an aligned press.
    $display("[TB] key 5 clean press");
    alignCol(1);
    exp_q.push_back(KEYCODE[1][1]);
    applyStimulus(1, 1, 1'b1);
    measureFlag("k5_flag", 60, k);
    checkOutput("k5_flag_latency", 32'(k), 32'(SCAN_DWELL + DEBOUNCE_CYC));
    waitCycles(60 - k);
    checkOutput("k5_key_down", 32'(key_down), 32'd1);
    checkOutput("k5_key_value", 32'(key_value), 32'h5);
    applyStimulus(1, 1, 1'b0);
    measureRelease("k5_release", 60, k);
    checkOutput("k5_release_latency", 32'(k), 32'(2 + DEBOUNCE_CYC));
    waitCycles(20);
    checkOutput("k5_queue_empty", 32'(exp_q.size()), 32'd0);

    // Key 'E' with press and release bounce.
    $display("[TB] key E bouncing");
    alignCol(2);
    exp_q.push_back(KEYCODE[3][2]);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(3, 2, ((i / 3) % 2) == 0);
      @(negedge CLK_1K);
    end
    applyStimulus(3, 2, 1'b1);
    waitCycles(50);
    checkOutput("ke_flag_seen", 32'(exp_q.size()), 32'd0);
    checkOutput("ke_key_value", 32'(key_value), 32'hE);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(3, 2, ((i / 3) % 2) == 1);
      @(negedge CLK_1K);
    end
    applyStimulus(3, 2, 1'b0);
    waitCycles(40);
    checkOutput("ke_key_down_released", 32'(key_down), 32'd0);

    // Keys '1' and '4' together: ghost, no flag, key_value keeps 'E'.
    $display("[TB] keys 1+4 together");
    alignCol(0);
    applyStimulus(0, 0, 1'b1);
    applyStimulus(1, 0, 1'b1);
    waitCycles(40);
    checkOutput("ghost_key_value", 32'(key_value), 32'hE);
    checkOutput("ghost_key_down", 32'(key_down), 32'd0);
    applyStimulus(0, 0, 1'b0);
    applyStimulus(1, 0, 1'b0);
    waitCycles(30);
    alignCol(0);
    exp_q.push_back(KEYCODE[2][0]);
    applyStimulus(2, 0, 1'b1);
    measureFlag("k7_flag", 60, k);
    checkOutput("k7_flag_latency", 32'(k), 32'(SCAN_DWELL + DEBOUNCE_CYC));
    checkOutput("k7_key_value", 32'(key_value), 32'h7);
    waitCycles(40 - k);
    applyStimulus(2, 0, 1'b0);
    waitCycles(30);

    // Sequence 1, 2, A, 3, E.
    $display("[TB] key sequence 1 2 A 3 E");
    for (int i = 0; i < 5; i++) begin
      alignCol(seq_c[i]);
      exp_q.push_back(KEYCODE[seq_r[i]][seq_c[i]]);
      applyStimulus(seq_r[i], seq_c[i], 1'b1);
      measureFlag("seq_flag", 60, k);
      checkOutput("seq_flag_latency", 32'(k), 32'(SCAN_DWELL + DEBOUNCE_CYC));
      waitCycles(30 - k);
      applyStimulus(seq_r[i], seq_c[i], 1'b0);
      waitCycles(30);
    end
    checkOutput("seq_last_value", 32'(key_value), 32'hE);
    checkOutput("seq_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset during debounce of '9', key still held afterwards.
    $display("[TB] reset during debounce of 9");
    alignCol(2);
    applyStimulus(2, 2, 1'b1);
    waitCycles(SCAN_DWELL + 10);
    #1 RST = 1'b0;
    waitCycles(3);
    #1 RST = 1'b1;
    exp_q.push_back(KEYCODE[2][2]);
    // After reset the scan restarts at column 0, so column 2 is sampled at 3*SCAN_DWELL.
    measureFlag("k9_flag", 60, k);
    checkOutput("k9_flag_latency", 32'(k), 32'(3 * SCAN_DWELL + DEBOUNCE_CYC));
    checkOutput("k9_key_value", 32'(key_value), 32'h9);
    waitCycles(10);
    applyStimulus(2, 2, 1'b0);
    waitCycles(30);
    checkOutput("final_key_down", 32'(key_down), 32'd0);
    checkOutput("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
